// File: rtl/tx_pkg.sv
// Shared transmitter types: pacer state encoding, default sample width,
// and the complex sample record used across the transmit datapath.
package tx_pkg;

  localparam int TX_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } pacer_state_e;

  typedef struct packed {
    logic signed [TX_DATA_W-1:0] re;
    logic signed [TX_DATA_W-1:0] im;
  } iq_t;

  // Width needed to hold an occupancy count of 0..depth inclusive.
  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/tx_iq_pacer_if.sv
// Sample-path bundle of the pacer.
// Handshake: a sample transfers on a cycle where in_valid and in_ready are
// both high; in_ready does not depend on in_valid. out_valid is a one-cycle
// pulse with no back-pressure, and out_re/out_im hold between pulses.
interface tx_iq_pacer_if #(
  parameter int DATA_W = tx_pkg::TX_DATA_W,
  parameter int LVL_W  = 4
);
  logic                     slow_en;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_re;
  logic signed [DATA_W-1:0] in_im;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_re;
  logic signed [DATA_W-1:0] out_im;
  logic [LVL_W-1:0]         level;
  logic                     underrun;

  // Pacer side
  modport slave (
    input  in_valid, in_re, in_im,
    output slow_en, in_ready, out_valid, out_re, out_im, level, underrun
  );

  // Upstream / consumer side
  modport master (
    output in_valid, in_re, in_im,
    input  slow_en, in_ready, out_valid, out_re, out_im, level, underrun
  );
endinterface

// File: rtl/tx_iq_fifo.sv
// Synchronous FIFO for packed I/Q samples with exact occupancy count and a
// synchronous flush. Pushes when full and pops when empty are ignored.
module tx_iq_fifo
  import tx_pkg::*;
#(
  parameter int W     = 2 * TX_DATA_W,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [W-1:0]                 wdata_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 rdata_o,
  output logic [lvl_width(DEPTH)-1:0]  level_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = lvl_width(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tx_iq_pacer.sv
// Single-clock I/Q output pacer: strobes the upstream slow chain once every
// DIV cycles, buffers its samples, and emits one sample per DIV cycles,
// substituting zeros (and latching underrun) when the buffer runs dry.
module tx_iq_pacer
  import tx_pkg::*;
#(
  parameter int DATA_W  = TX_DATA_W,
  parameter int DEPTH   = 8,
  parameter int DIV     = 3,
  parameter int PREFILL = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  tx_iq_pacer_if.slave bus,
  output pacer_state_e dbg_state_o
);
  localparam int LVL_W  = lvl_width(DEPTH);
  localparam int LVL1_W = LVL_W + 1;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;

  pacer_state_e             state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     out_valid_q, underrun_q;
  logic signed [DATA_W-1:0] out_re_q, out_im_q;

  logic                     tick, push, pop, flush, full, empty, in_ready;
  logic [LVL_W-1:0]         level;
  logic [LVL1_W-1:0]        level_d;
  logic [2*DATA_W-1:0]      head;

  assign tick     = (cnt_q == CNT_W'(DIV - 1));
  assign in_ready = (state_q != ST_IDLE) && !full;
  assign push     = bus.in_valid && in_ready;
  assign pop      = (state_q == ST_RUN) && tick && enable;
  // Leaving or sitting in IDLE discards whatever is buffered.
  assign flush    = (state_q == ST_IDLE) || !enable;
  // Occupancy after this cycle's push; FILL never pops.
  assign level_d  = {1'b0, level} + {{LVL_W{1'b0}}, push};

  tx_iq_fifo #(
    .W     (2 * DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i ({bus.in_re, bus.in_im}),
    .pop_i   (pop),
    .rdata_o (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  // Pacer FSM, phase counter and registered sample output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      underrun_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q       <= '0;
          out_valid_q <= 1'b0;
          out_re_q    <= '0;
          out_im_q    <= '0;
          if (enable) begin
            state_q    <= ST_FILL;
            underrun_q <= 1'b0;
          end
        end
        default: begin
          if (!enable) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
          end else begin
            cnt_q       <= tick ? '0 : cnt_q + CNT_W'(1);
            out_valid_q <= 1'b0;
            if (state_q == ST_FILL) begin
              // Phase keeps running across the FILL->RUN hand-over.
              if (level_d >= LVL1_W'(PREFILL)) state_q <= ST_RUN;
            end else if (tick) begin
              out_valid_q <= 1'b1;
              if (empty) begin
                out_re_q   <= '0;
                out_im_q   <= '0;
                underrun_q <= 1'b1;
              end else begin
                out_re_q <= head[2*DATA_W-1:DATA_W];
                out_im_q <= head[DATA_W-1:0];
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.slow_en   = tick && (state_q != ST_IDLE);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.level     = level;
  assign bus.underrun  = underrun_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/tx_iq_pacer.md
Name: tx_iq_pacer

Overview:
- Single-clock rate pacer for the transmitter's complex-sample output path.
- Replaces the gated-clock / derived slow-clock scheme.
- Generates a 1-of-DIV clock-enable strobe for the upstream slow-rate chain.
- Buffers that chain's I/Q samples in a small FIFO and emits exactly one sample every DIV cycles, inserting zeros and flagging underrun when starved.

Parameters:
- DATA_W, 16: width of each signed real/imag sample.
- DEPTH, 8: FIFO depth in samples. Power of 2, ≥2.
- DIV, 3: output sample interval in clk cycles. ≥1.
- PREFILL, 4: samples buffered before output starts. 1..DEPTH.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run request. Low forces IDLE.
- slow_en  out  1  one-cycle strobe every DIV cycles for upstream logic.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  pacer can accept a sample.
- in_re  in  DATA_W  signed real input.
- in_im  in  DATA_W  signed imag input.
- out_valid  out  1  one-cycle pulse per emitted sample.
- out_re  out  DATA_W  signed real output, held between pulses.
- out_im  out  DATA_W  signed imag output, held between pulses.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- underrun  out  1  sticky: a tick found the FIFO empty.

Behaviour:
- Reset, asynchronous on reset_n low:
  - state=IDLE, cnt=0, FIFO pointers and level=0.
  - All outputs 0.
- States: IDLE, FILL, RUN.
- IDLE:
  - in_ready=0, slow_en=0, cnt held at 0.
  - FIFO is flushed (level→0).
  - out_re/out_im/out_valid are 0.
  - enable=1 → FILL next cycle; underrun is cleared on this transition.
- Phase counter cnt:
  - Counts 0..DIV-1 and wraps, in FILL and RUN only.
  - tick = (cnt==DIV-1). slow_en = tick, combinational from registered cnt.
  - DIV=1 gives tick every cycle.
- Push: in_valid & in_ready writes {in_re,in_im}.
  - in_ready = (state!=IDLE) & (level<DEPTH). Registered level is used; no full-pass-through.
  - A push while in_ready=0 is ignored and dropped. Upstream must honour ready.
- FILL:
  - Pushes only, no pops.
  - When level (after this cycle's update) ≥ PREFILL → RUN next cycle.
  - cnt is NOT reset on this transition.
- RUN, on each tick cycle:
  - If level>0: pop the head into out_re/out_im, registered. out_valid=1 the following cycle.
  - If level==0: out_re=out_im=0, out_valid=1, underrun←1. State stays RUN.
  - Non-tick cycles: out_valid=0, out_re/out_im hold.
- Simultaneous push and pop in one cycle: level unchanged, both take effect. Full and pop in the same cycle still refuses the push (ready already 0).
- Pointers wrap modulo DEPTH. level is the exact count 0..DEPTH.
- enable low in FILL or RUN:
  - IDLE next cycle. Pending samples are discarded.
  - out_valid is 0 and outputs are zeroed from that next cycle.
  - underrun holds its value until re-entry to FILL.
- Reset mid-operation: immediate return to reset values. No completion of an in-flight sample.
- Latency:
  - A sample popped on tick cycle t appears with out_valid at t+1.
  - The first out_valid after RUN entry occurs within DIV cycles.

Decomposition:
- Package tx_pkg holds:
  - pacer state enum (IDLE/FILL/RUN);
  - DATA_W default;
  - iq_t sample struct {re,im}, shared with transmitter datapath blocks.
- One natural sub-module: tx_iq_fifo.
  - Synchronous FIFO, parametrised width 2*DATA_W and DEPTH.
  - Provides push/pop/level/full/empty.
- The pacer FSM and phase counter live in the top module.

Test Plan:
- Reset: assert reset_n=0 mid-run with level=5 → all outputs 0, level=0 asynchronously, state IDLE; no out_valid after release until enable.
- Steady stream, DIV=3, DEPTH=8, PREFILL=4: push ramp re=1..20, im=-1..-20 on every slow_en → out_valid every 3 cycles, out_re 1..20 in order; level stays ≥3; underrun=0.
- Underrun: after PREFILL=4 samples, stop in_valid → four pulses carrying samples 1..4, then out_valid pulses with re=im=0 and underrun=1 sticky. Resume pushing → data resumes; underrun stays 1 until enable toggles.
- Full: hold in_valid=1 every cycle, DIV=3 → level saturates at 8, in_ready=0 at full. Only accepted samples are output, strictly in order.
- Enable drop mid-RUN with level=6 → IDLE next cycle, level=0, outputs 0. Re-enable → FILL, underrun cleared, first output is the first newly pushed sample.
- DIV=1, PREFILL=1: slow_en constantly 1. Push one sample per cycle → out_valid continuous with 1-cycle latency after RUN entry; no underrun.
